// File: rtl/multicycle_control_fsm_pkg.sv
// Opcode/ALUOp/source-select constants, state encoding and the per-state
// output decode for the multicycle MIPS control unit.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_ILLEGAL  = 4'd12,
        S_IRQ      = 4'd13
    } state_t;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       pc_source;
        logic       pc_write;
        logic       is_branch;
        logic       lord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       is_interrupted;
        logic       illegal_op;
    } ctrl_t;

    // last_cycle marks the final cycle of a memory wait state
    function automatic ctrl_t decode_outputs(input state_t st, input logic last_cycle);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = last_cycle;
                c.pc_write  = last_cycle;
            end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.lord = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                c.lord      = 1'b1;
                c.mem_write = last_cycle;
            end
            S_EXECUTE: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALUOP_SUB;
                c.is_branch   = 1'b1;
                c.pc_source   = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:   c.reg_write  = 1'b1;
            S_ILLEGAL:  c.illegal_op = 1'b1;
            S_IRQ: begin
                c.is_interrupted = 1'b1;
                c.pc_write       = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter: clear/increment, saturating at MEM_WAIT, with the
// done flag for the current count and for the count about to be registered.
module ctrl_wait_timer #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic done,
    output logic done_d
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_WAIT);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT)) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done   = (count_q == LIMIT);
    assign done_d = (count_d == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath. Define CTRL_IRQ_EN to
// enable the IRQ state and irq sampling at instruction completion.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       irq,
    output logic [1:0] aluControl,
    output logic [1:0] aluSrcB,
    output logic       aluSrcA,
    output logic       PCSource,
    output logic       PCWrite,
    output logic       isBranch,
    output logic       lorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       isInterrupted,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    state_t retire_state;
    ctrl_t  out_q;
    ctrl_t  out_d;
    logic   wait_clr;
    logic   wait_inc;
    logic   wait_done;
    logic   wait_done_d;
    logic   unused_sink;

`ifdef CTRL_IRQ_EN
    assign retire_state = irq ? S_IRQ : S_FETCH;
`else
    assign retire_state = S_FETCH;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    if (wait_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (wait_done) state_d = S_MEMWB;
            S_MEMWRITE: if (wait_done) state_d = retire_state;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_ILLEGAL:
                        state_d = retire_state;
            default:    state_d = S_FETCH;
        endcase
    end

    // Counter restarts on every transition so each wait state sees a fresh count
    assign wait_clr = (state_d != state_q);
    assign wait_inc = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    ctrl_wait_timer #(
        .MEM_WAIT (MEM_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk    (clk),
        .srst   (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .done   (wait_done),
        .done_d (wait_done_d)
    );

    // Outputs are decoded from the next state so the registered copy lines up with state_q
    assign out_d = decode_outputs(state_d, wait_done_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign aluControl = out_q.alu_control;
    assign aluSrcB    = out_q.alu_src_b;
    assign aluSrcA    = out_q.alu_src_a;
    assign PCSource   = out_q.pc_source;
    assign PCWrite    = out_q.pc_write;
    assign isBranch   = out_q.is_branch;
    assign lorD       = out_q.lord;
    assign MemWrite   = out_q.mem_write;
    assign IRWrite    = out_q.ir_write;
    assign RegWrite   = out_q.reg_write;
    assign RegDst     = out_q.reg_dst;
    assign MemtoReg   = out_q.mem_to_reg;
    assign illegal_op = out_q.illegal_op;

`ifdef CTRL_IRQ_EN
    assign isInterrupted = out_q.is_interrupted;
`else
    assign isInterrupted = 1'b0;
`endif

    // funct is decoded by the datapath ALU decoder, not here
    assign unused_sink = ^{funct, irq, out_q.is_interrupted};

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one instance at MEM_WAIT=0 and one
// at MEM_WAIT=2, outputs packed into a 16-bit vector and compared per cycle.
module tb_multicycle_control_fsm;

    // {aluControl[1:0], aluSrcB[1:0], aluSrcA, PCSource, PCWrite, isBranch,
    //  lorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, isInterrupted, illegal_op}
    localparam logic [15:0] E_ZERO     = 16'h0000;
    localparam logic [15:0] E_FETCH_W  = 16'h1000;
    localparam logic [15:0] E_FETCH    = 16'h1220;
    localparam logic [15:0] E_DECODE   = 16'h3000;
    localparam logic [15:0] E_MEMADR   = 16'h2800;
    localparam logic [15:0] E_MEMRD    = 16'h0080;
    localparam logic [15:0] E_MEMWB    = 16'h0014;
    localparam logic [15:0] E_MEMWR_W  = 16'h0080;
    localparam logic [15:0] E_MEMWR    = 16'h00C0;
    localparam logic [15:0] E_EXECUTE  = 16'h8800;
    localparam logic [15:0] E_ALUWB    = 16'h0018;
    localparam logic [15:0] E_BRANCH   = 16'h4D00;
    localparam logic [15:0] E_ADDIEX   = 16'h2800;
    localparam logic [15:0] E_ADDIWB   = 16'h0010;
    localparam logic [15:0] E_ILLEGAL  = 16'h0001;
    localparam logic [15:0] E_IRQ      = 16'h0202;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       irq   = 1'b0;
    logic [5:0] op    = 6'b000000;
    logic [5:0] funct = 6'b100000;

    logic [1:0] ctl0, srcb0, ctl2, srcb2;
    logic srca0, pcs0, pcw0, br0, lord0, mw0, irw0, rw0, rd0, m2r0, int0, ill0;
    logic srca2, pcs2, pcw2, br2, lord2, mw2, irw2, rw2, rd2, m2r2, int2, ill2;
    logic [15:0] v0, v2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_WAIT(0), .WAIT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .irq(irq),
        .aluControl(ctl0), .aluSrcB(srcb0), .aluSrcA(srca0), .PCSource(pcs0),
        .PCWrite(pcw0), .isBranch(br0), .lorD(lord0), .MemWrite(mw0),
        .IRWrite(irw0), .RegWrite(rw0), .RegDst(rd0), .MemtoReg(m2r0),
        .isInterrupted(int0), .illegal_op(ill0)
    );

    multicycle_control_fsm #(.MEM_WAIT(2), .WAIT_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .irq(irq),
        .aluControl(ctl2), .aluSrcB(srcb2), .aluSrcA(srca2), .PCSource(pcs2),
        .PCWrite(pcw2), .isBranch(br2), .lorD(lord2), .MemWrite(mw2),
        .IRWrite(irw2), .RegWrite(rw2), .RegDst(rd2), .MemtoReg(m2r2),
        .isInterrupted(int2), .illegal_op(ill2)
    );

    assign v0 = {ctl0, srcb0, srca0, pcs0, pcw0, br0, lord0, mw0, irw0, rw0, rd0, m2r0, int0, ill0};
    assign v2 = {ctl2, srcb2, srca2, pcs2, pcw2, br2, lord2, mw2, irw2, rw2, rd2, m2r2, int2, ill2};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%h", tag, got);
        end else begin
            $display("FAIL %-14s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, then compare the chosen instance against exp
    task automatic chk(input string tag, input int which, input logic [15:0] exp);
        step();
        check_eq(tag, (which == 2) ? v2 : v0, exp);
    endtask

    task automatic apply_reset(input logic [5:0] op_i);
        reset = 1'b1;
        op    = op_i;
        repeat (3) begin
            step();
            check_eq("in_reset0", v0, E_ZERO);
            check_eq("in_reset2", v2, E_ZERO);
        end
        reset = 1'b0;
        check_eq("rst_state0", v0, E_ZERO);
        check_eq("rst_state2", v2, E_ZERO);
    endtask

    initial begin
        // R-type at MEM_WAIT=0; also first FETCH cycle of the MEM_WAIT=2 instance
        apply_reset(6'b000000);
        step();
        check_eq("rt_fetch", v0, E_FETCH);
        check_eq("fetch_w2", v2, E_FETCH_W);
        chk("rt_decode",  0, E_DECODE);
        chk("rt_execute", 0, E_EXECUTE);
        chk("rt_aluwb",   0, E_ALUWB);
        chk("rt_next",    0, E_FETCH);

        // lw at MEM_WAIT=2: 9 cycles
        apply_reset(6'b100011);
        chk("lw_fetch_a", 2, E_FETCH_W);
        chk("lw_fetch_b", 2, E_FETCH_W);
        chk("lw_fetch_c", 2, E_FETCH);
        chk("lw_decode",  2, E_DECODE);
        chk("lw_memadr",  2, E_MEMADR);
        chk("lw_memrd_a", 2, E_MEMRD);
        chk("lw_memrd_b", 2, E_MEMRD);
        chk("lw_memrd_c", 2, E_MEMRD);
        chk("lw_memwb",   2, E_MEMWB);
        chk("lw_next",    2, E_FETCH_W);

        // sw at MEM_WAIT=2: MemWrite only on the final MEMWRITE cycle
        apply_reset(6'b101011);
        repeat (5) step();
        chk("sw2_memwr_a", 2, E_MEMWR_W);
        chk("sw2_memwr_b", 2, E_MEMWR_W);
        chk("sw2_memwr_c", 2, E_MEMWR);
        chk("sw2_next",    2, E_FETCH_W);

        // beq
        apply_reset(6'b000100);
        chk("beq_fetch",  0, E_FETCH);
        chk("beq_decode", 0, E_DECODE);
        chk("beq_branch", 0, E_BRANCH);
        chk("beq_next",   0, E_FETCH);

        // addi
        apply_reset(6'b001000);
        chk("addi_fetch", 0, E_FETCH);
        chk("addi_dec",   0, E_DECODE);
        chk("addi_ex",    0, E_ADDIEX);
        chk("addi_wb",    0, E_ADDIWB);
        chk("addi_next",  0, E_FETCH);

        // unsupported opcode
        apply_reset(6'b111111);
        chk("ill_fetch",  0, E_FETCH);
        chk("ill_decode", 0, E_DECODE);
        chk("ill_pulse",  0, E_ILLEGAL);
        chk("ill_next",   0, E_FETCH);
        chk("ill_decode2", 0, E_DECODE);

        // reset in the middle of an R-type abandons it
        apply_reset(6'b000000);
        chk("ab_fetch",   0, E_FETCH);
        chk("ab_decode",  0, E_DECODE);
        chk("ab_execute", 0, E_EXECUTE);
        reset = 1'b1;
        chk("ab_reset",   0, E_ZERO);

        // sw with irq held high
        irq = 1'b1;
        apply_reset(6'b101011);
        chk("irq_fetch",  0, E_FETCH);
        chk("irq_decode", 0, E_DECODE);
        chk("irq_memadr", 0, E_MEMADR);
        chk("irq_memwr",  0, E_MEMWR);
`ifdef CTRL_IRQ_EN
        chk("irq_entry",  0, E_IRQ);
`endif
        chk("irq_fetch2", 0, E_FETCH);
        chk("irq_dec2",   0, E_DECODE);
        chk("irq_madr2",  0, E_MEMADR);
        chk("irq_memwr2", 0, E_MEMWR);
`ifdef CTRL_IRQ_EN
        chk("irq_entry2", 0, E_IRQ);
`endif
        chk("irq_fetch3", 0, E_FETCH);
        irq = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
